scan_mux: RTL and testbench

//  Parametrised, registered N_CH:1 multiplexer of W-bit channels with a request/handshake front end.
//  - Manual mode: captures one channel selected by sel_in.
//  - Scan mode: steps a channel counter through all channels.
//  - Each sample is presented with out_valid/out_ready backpressure.
//  - Successor to the combinational 16:1 mux; feeds channel data to downstream sequential logic.

---
 rtl/scan_mux_pkg.sv | 13 +
 rtl/scan_mux_next_ch.sv | 26 ++
 rtl/scan_mux.sv | 158 +++++++++++++++
 tb/tb_scan_mux.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_mux_pkg.sv
// Shared types and default sizing for the scan_mux block.
package scan_mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N_CH = 16;
  localparam int DEF_W    = 1;

endpackage

// File: rtl/scan_mux_next_ch.sv
// scan_next_ch: combinational search for the lowest set mask bit strictly above ptr.
// Used by scan_mux only when SCAN_MASK_EN is defined.
module scan_next_ch #(
  parameter int N_CH  = 16,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);

  // Walk downwards so the lowest qualifying channel is the last one written.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
    nxt   = '0;
    found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(ptr))) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_mux.sv
// scan_mux: registered N_CH:1 channel multiplexer with manual/scan request front end
// and out_valid/out_ready backpressure.
// Optional feature macro: SCAN_MASK_EN (adds ch_mask; scan visits only enabled channels).
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int W     = DEF_W,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] d,
  input  logic              req,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel_in,
`ifdef SCAN_MASK_EN
  input  logic [N_CH-1:0]   ch_mask,
`endif
  output logic [W-1:0]      op,
  output logic [SEL_W-1:0]  chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [SEL_W-1:0] sel_clamped, first_ch, step_ch;
  logic [W-1:0]     slice;
  logic             mode_q, accept, load, valid_nxt, more, any_set;

  assign accept = (state == IDLE) && req;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  // Out-of-range manual selects (non-power-of-2 N_CH) map to the last channel.
  always_comb begin
    sel_clamped = sel_in;
    if (int'(sel_in) > N_CH - 1) sel_clamped = LAST;
  end

`ifdef SCAN_MASK_EN
  logic [N_CH-1:0]  mask_q;
  logic [SEL_W-1:0] above0;
  logic             found0;

  // First channel of a scan comes from the live mask at the accepting edge.
  scan_next_ch #(.N_CH(N_CH), .SEL_W(SEL_W)) u_first (
    .mask (ch_mask),
    .ptr  ('0),
    .nxt  (above0),
    .found(found0)
  );

  // Successor of ptr comes from the mask latched with the request.
  scan_next_ch #(.N_CH(N_CH), .SEL_W(SEL_W)) u_step (
    .mask (mask_q),
    .ptr  (ptr),
    .nxt  (step_ch),
    .found(more)
  );

  assign any_set  = ch_mask[0] | found0;
  assign first_ch = ch_mask[0] ? '0 : above0;

  // Mask is captured only when a request is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         mask_q <= '0;
    else if (accept) mask_q <= ch_mask;
  end
`else
  assign any_set  = 1'b1;
  assign first_ch = '0;
  assign step_ch  = ptr + 1'b1;
  assign more     = (ptr != LAST);
`endif

  // Next state, next pointer and capture strobe.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    load      = 1'b0;
    valid_nxt = out_valid;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (req) begin
          if (mode && !any_set) begin
            state_nxt = DONE;
          end else begin
            ptr_nxt   = mode ? first_ch : sel_clamped;
            load      = 1'b1;
            valid_nxt = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (mode_q && more) begin
            ptr_nxt = step_ch;
            load    = 1'b1;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Channel-slice mux on the pointer being captured this edge.
  always_comb begin
    slice = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ptr_nxt == SEL_W'(i)) slice = d[i*W +: W];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Pointer, latched mode and output sample registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      mode_q    <= 1'b0;
      op        <= '0;
      chan      <= '0;
      out_valid <= 1'b0;
    end else begin
      ptr       <= ptr_nxt;
      out_valid <= valid_nxt;
      if (accept) mode_q <= mode;
      if (load) begin
        op   <= slice;
        chan <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: a 16x1 instance and a 5x8 instance.
module tb_scan_mux;

`ifdef SCAN_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] d16;
  logic        req16, mode16, rdy16;
  logic [3:0]  sel16, chan16;
  logic [0:0]  op16;
  logic        vld16, busy16, done16;

  logic [39:0] d5;
  logic        req5, mode5, rdy5;
  logic [2:0]  sel5, chan5;
  logic [7:0]  op5;
  logic        vld5, busy5, done5;

`ifdef SCAN_MASK_EN
  logic [15:0] mask16;
  logic [4:0]  mask5;
`endif

  int checks   = 0;
  int failures = 0;

  scan_mux #(.N_CH(16), .W(1)) u16 (
    .clk(clk), .rst(rst), .d(d16), .req(req16), .mode(mode16), .sel_in(sel16),
`ifdef SCAN_MASK_EN
    .ch_mask(mask16),
`endif
    .op(op16), .chan(chan16), .out_valid(vld16), .out_ready(rdy16),
    .busy(busy16), .done(done16)
  );

  scan_mux #(.N_CH(5), .W(8)) u5 (
    .clk(clk), .rst(rst), .d(d5), .req(req5), .mode(mode5), .sel_in(sel5),
`ifdef SCAN_MASK_EN
    .ch_mask(mask5),
`endif
    .op(op5), .chan(chan5), .out_valid(vld5), .out_ready(rdy5),
    .busy(busy5), .done(done5)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_mask16_all();
`ifdef SCAN_MASK_EN
    mask16 = 16'hFFFF;
`endif
  endtask

  // Wait (bounded) for the done pulse on the 16-channel instance with ready high.
  task automatic drain16();
    int cyc = 0;
    rdy16 = 1'b1;
    while (!done16 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_done", done16, 1'b1);
    @(negedge clk);
    check("drain_idle", busy16, 1'b0);
  endtask

  // One transaction on the 16-channel instance against a list-of-channels model.
  task automatic run16(input bit m, input logic [3:0] s, input logic [15:0] dv,
                       input logic [15:0] mk, input int rdy_pct);
    int   q[$];
    logic exp_op;
    int   cyc;
    exp_op = 1'b0;
    if (m) begin
      for (int i = 0; i < 16; i++)
        if (mk[i] || !MASK_EN) q.push_back(i);
    end else begin
      q.push_back(int'(s));
    end
    @(negedge clk);
    d16 = dv; mode16 = m; sel16 = s; req16 = 1'b1;
`ifdef SCAN_MASK_EN
    mask16 = mk;
`endif
    if (q.size() > 0) exp_op = dv[q[0]];
    @(negedge clk);
    cyc = 0;
    while (q.size() > 0 && cyc < 300) begin
      check("txn_valid", vld16, 1'b1);
      check("txn_chan", chan16, q[0]);
      check("txn_op", op16, exp_op);
      check("txn_busy", busy16, 1'b1);
      req16  = 1'($urandom_range(0, 1));
      mode16 = 1'($urandom);
      sel16  = 4'($urandom);
`ifdef SCAN_MASK_EN
      mask16 = 16'($urandom);
`endif
      d16   = 16'($urandom);
      rdy16 = ($urandom_range(1, 100) <= rdy_pct);
      if (rdy16) begin
        q.delete(0);
        if (q.size() > 0) exp_op = d16[q[0]];
      end
      @(negedge clk);
      cyc++;
    end
    check("txn_timeout", q.size(), 0);
    check("txn_done", done16, 1'b1);
    check("txn_valid_off", vld16, 1'b0);
    req16 = 1'b1;
    @(negedge clk);
    check("txn_done_once", done16, 1'b0);
    check("txn_idle", busy16, 1'b0);
    req16 = 1'b0;
    @(negedge clk);
    check("txn_not_queued", busy16, 1'b0);
  endtask

  typedef struct {
    logic [15:0] d;
    logic [3:0]  sel;
    logic        op;
  } man_vec_t;

  man_vec_t tbl[6];
  logic     scan_a5[16];
  logic [7:0] ex5[5];

  initial begin
    int cyc;
    logic [15:0] dnow;

    tbl[0] = '{16'h0020, 4'd5,  1'b1};
    tbl[1] = '{16'h0020, 4'd4,  1'b0};
    tbl[2] = '{16'h8000, 4'd15, 1'b1};
    tbl[3] = '{16'h0001, 4'd0,  1'b1};
    tbl[4] = '{16'hFFFE, 4'd0,  1'b0};
    tbl[5] = '{16'h7FFF, 4'd15, 1'b0};
    scan_a5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ex5 = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};

    rst = 1'b1;
    d16 = '0; req16 = 0; mode16 = 0; rdy16 = 0; sel16 = '0;
    d5 = '0; req5 = 0; mode5 = 0; rdy5 = 0; sel5 = '0;
`ifdef SCAN_MASK_EN
    mask16 = '1; mask5 = '1;
`endif
    #12;
    check("rst_op", op16, 1'b0);
    check("rst_chan", chan16, 4'd0);
    check("rst_valid", vld16, 1'b0);
    check("rst_busy", busy16, 1'b0);
    check("rst_done", done16, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_valid", vld16, 1'b0);

    // Manual captures from the vector table.
    foreach (tbl[k]) begin
      d16 = tbl[k].d; sel16 = tbl[k].sel; mode16 = 1'b0; req16 = 1'b1; rdy16 = 1'b1;
      @(negedge clk);
      req16 = 1'b0;
      check("man_valid", vld16, 1'b1);
      check("man_op", op16, tbl[k].op);
      check("man_chan", chan16, tbl[k].sel);
      @(negedge clk);
      check("man_done", done16, 1'b1);
      @(negedge clk);
      check("man_done_once", done16, 1'b0);
      check("man_busy_off", busy16, 1'b0);
    end

    // Full scan of A5A5 with ready tied high.
    set_mask16_all();
    d16 = 16'hA5A5; mode16 = 1'b1; req16 = 1'b1; rdy16 = 1'b1;
    @(negedge clk);
    req16 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("scan_valid", vld16, 1'b1);
      check("scan_chan", chan16, i);
      check("scan_op", op16, scan_a5[i]);
      @(negedge clk);
    end
    check("scan_done", done16, 1'b1);
    check("scan_valid_off", vld16, 1'b0);
    @(negedge clk);
    check("scan_idle", busy16, 1'b0);

    // Backpressure at chan 3 with d toggling.
    d16 = 16'h0008; mode16 = 1'b1; req16 = 1'b1; rdy16 = 1'b1;
    @(negedge clk);
    req16 = 1'b0;
    cyc = 0;
    while (chan16 != 4'd3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_reach3", chan16, 4'd3);
    rdy16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d16 = ~d16;
      @(negedge clk);
      check("bp_hold_chan", chan16, 4'd3);
      check("bp_hold_op", op16, 1'b1);
      check("bp_hold_valid", vld16, 1'b1);
    end
    dnow = 16'h0010;
    d16 = dnow; rdy16 = 1'b1;
    @(negedge clk);
    check("bp_adv_chan", chan16, 4'd4);
    check("bp_adv_op", op16, dnow[4]);
    drain16();

    // Asynchronous reset mid-scan at chan 7.
    d16 = 16'hFFFF; mode16 = 1'b1; req16 = 1'b1; rdy16 = 1'b1;
    @(negedge clk);
    req16 = 1'b0;
    cyc = 0;
    while (chan16 != 4'd7 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("mr_reach7", chan16, 4'd7);
    check("mr_op_pre", op16, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mr_op", op16, 1'b0);
    check("mr_chan", chan16, 4'd0);
    check("mr_valid", vld16, 1'b0);
    check("mr_busy", busy16, 1'b0);
    check("mr_done", done16, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    d16 = 16'h0001; mode16 = 1'b1; req16 = 1'b1;
    @(negedge clk);
    req16 = 1'b0;
    check("mr_restart_chan", chan16, 4'd0);
    check("mr_restart_op", op16, 1'b1);
    drain16();

    // Five channels of eight bits: scan and clamped manual select.
    d5 = {8'h44, 8'h33, 8'h22, 8'h11, 8'h00}; mode5 = 1'b1; req5 = 1'b1; rdy5 = 1'b1;
    @(negedge clk);
    req5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("w8_valid", vld5, 1'b1);
      check("w8_chan", chan5, i);
      check("w8_op", op5, ex5[i]);
      @(negedge clk);
    end
    check("w8_done", done5, 1'b1);
    @(negedge clk);
    check("w8_idle", busy5, 1'b0);
    for (int s = 5; s < 8; s++) begin
      sel5 = 3'(s); mode5 = 1'b0; req5 = 1'b1;
      @(negedge clk);
      req5 = 1'b0;
      check("w8_clamp_op", op5, 8'h44);
      check("w8_clamp_chan", chan5, 3'd4);
      @(negedge clk);
      check("w8_clamp_done", done5, 1'b1);
      @(negedge clk);
    end

`ifdef SCAN_MASK_EN
    // Sparse mask, empty mask, and manual mode ignoring the mask.
    run16(1'b1, 4'd0, 16'h8001, 16'h8001, 100);
    run16(1'b1, 4'd0, 16'hFFFF, 16'h0000, 100);
    run16(1'b0, 4'd9, 16'h0200, 16'h0000, 60);
`endif

    // Randomised transactions against the channel-list model.
    for (int t = 0; t < 40; t++) begin
      logic [15:0] mk;
      mk = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      run16(1'($urandom), 4'($urandom), 16'($urandom), mk, 70);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
